// File: rtl/grid_row_scanner_if.sv
// Signal bundle between the grid controller register slave (master side) and the
// row scanner (slave side): write strobes, control levels, readback and display outputs.
interface grid_row_scanner_if #(
  parameter int COLS  = 32,
  parameter int ROWS  = 16,
  parameter int ROW_W = 4,
  parameter int DIV_W = 16
);
  logic             cfg_wr_stb;
  logic [ROW_W:0]   cfg_row;
  logic [COLS-1:0]  cfg_data;
  logic             ctrl_enable;
  logic             ctrl_clear;
  logic [DIV_W-1:0] scan_div;
  logic [ROW_W-1:0] rd_row;
  logic [COLS-1:0]  rd_data;
  logic [ROWS-1:0]  row_sel;
  logic [COLS-1:0]  col_data;
  logic             frame_done;
  logic             busy;

  modport master (
    output cfg_wr_stb, cfg_row, cfg_data, ctrl_enable, ctrl_clear, scan_div, rd_row,
    input  rd_data, row_sel, col_data, frame_done, busy
  );

  modport slave (
    input  cfg_wr_stb, cfg_row, cfg_data, ctrl_enable, ctrl_clear, scan_div, rd_row,
    output rd_data, row_sel, col_data, frame_done, busy
  );
endinterface

// File: rtl/grid_row_scanner.sv
// Row-multiplexed grid display scanner with register-write grid store and readback.
// Optional double-buffered grid when GRID_SHADOW_EN is defined (banks swap on frame_done).
module grid_row_scanner #(
  parameter int COLS  = 32,
  parameter int ROWS  = 16,
  parameter int ROW_W = 4,
  parameter int DIV_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  grid_row_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_BLANK = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] clr_row_q;
  logic [DIV_W-1:0] cnt_q;
  logic [ROWS-1:0]  row_sel_q;
  logic [COLS-1:0]  col_data_q;
  logic [COLS-1:0]  rd_data_q;
  logic             frame_done_q;
  logic             busy_q;

  logic [COLS-1:0]  bank0_q [ROWS];
`ifdef GRID_SHADOW_EN
  logic [COLS-1:0]  bank1_q [ROWS];
  logic             disp_q;
`endif

  logic             wr_en_s;
  logic [ROW_W-1:0] wr_idx_s;
  logic [COLS-1:0]  scan_word_s;
  logic [COLS-1:0]  rd_word_s;

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    logic [ROWS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

  // Write qualification and displayed-bank read ports
  always_comb begin
    wr_en_s  = bus.cfg_wr_stb && (bus.cfg_row < (ROW_W+1)'(ROWS)) &&
               (state_q != ST_CLEAR) && !bus.ctrl_clear;
    wr_idx_s = bus.cfg_row[ROW_W-1:0];
`ifdef GRID_SHADOW_EN
    if (disp_q) begin
      scan_word_s = bank1_q[row_q];
      rd_word_s   = bank1_q[bus.rd_row];
    end else begin
      scan_word_s = bank0_q[row_q];
      rd_word_s   = bank0_q[bus.rd_row];
    end
`else
    scan_word_s = bank0_q[row_q];
    rd_word_s   = bank0_q[bus.rd_row];
`endif
  end

  // Grid store: clear sweep has priority, otherwise accepted writes (to back bank when shadowed)
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bank0_q <= '{default: '0};
`ifdef GRID_SHADOW_EN
      bank1_q <= '{default: '0};
`endif
    end else if (state_q == ST_CLEAR) begin
      bank0_q[clr_row_q] <= '0;
`ifdef GRID_SHADOW_EN
      bank1_q[clr_row_q] <= '0;
`endif
    end else if (wr_en_s) begin
`ifdef GRID_SHADOW_EN
      if (disp_q) begin
        bank0_q[wr_idx_s] <= bus.cfg_data;
      end else begin
        bank1_q[wr_idx_s] <= bus.cfg_data;
      end
`else
      bank0_q[wr_idx_s] <= bus.cfg_data;
`endif
    end
  end

  // Scan sequencer with registered display outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      clr_row_q    <= '0;
      cnt_q        <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef GRID_SHADOW_EN
      disp_q       <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (bus.ctrl_clear) begin
        state_q    <= ST_CLEAR;
        clr_row_q  <= '0;
        row_q      <= '0;
        cnt_q      <= '0;
        row_sel_q  <= '0;
        col_data_q <= '0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.ctrl_enable) begin
              state_q    <= ST_SCAN;
              row_sel_q  <= row_onehot(row_q);
              col_data_q <= scan_word_s;
              cnt_q      <= bus.scan_div;
            end
          end
          ST_CLEAR: begin
            if (clr_row_q == LAST_ROW) begin
              busy_q <= 1'b0;
              if (bus.ctrl_enable) begin
                state_q    <= ST_SCAN;
                row_sel_q  <= row_onehot(row_q);
                col_data_q <= scan_word_s;
                cnt_q      <= bus.scan_div;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              clr_row_q <= clr_row_q + ROW_W'(1);
            end
          end
          ST_SCAN: begin
            if (!bus.ctrl_enable) begin
              state_q    <= ST_IDLE;
              row_q      <= '0;
              cnt_q      <= '0;
              row_sel_q  <= '0;
              col_data_q <= '0;
            end else if (cnt_q == '0) begin
              // Row pointer advances on blank entry so the next SCAN reads the new row
              state_q   <= ST_BLANK;
              row_sel_q <= '0;
              if (row_q == LAST_ROW) begin
                row_q        <= '0;
                frame_done_q <= 1'b1;
`ifdef GRID_SHADOW_EN
                disp_q       <= ~disp_q;
`endif
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end
          ST_BLANK: begin
            if (!bus.ctrl_enable) begin
              state_q    <= ST_IDLE;
              row_q      <= '0;
              cnt_q      <= '0;
              row_sel_q  <= '0;
              col_data_q <= '0;
            end else begin
              state_q    <= ST_SCAN;
              row_sel_q  <= row_onehot(row_q);
              col_data_q <= scan_word_s;
              cnt_q      <= bus.scan_div;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            row_sel_q  <= '0;
            col_data_q <= '0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Readback port, one cycle latency from rd_row
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_word_s;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.col_data   = col_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_grid_row_scanner.sv
// Self-checking bench for grid_row_scanner: per-cycle comparison against a behavioural
// display model, plus directed scenarios with hand-computed literal expectations.
module tb_grid_row_scanner;
  localparam int COLS  = 32;
  localparam int ROWS  = 16;
  localparam int ROW_W = 4;
  localparam int DIV_W = 16;
`ifdef GRID_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grid_row_scanner_if #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .DIV_W(DIV_W)) bus ();

  grid_row_scanner #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .DIV_W(DIV_W)) dut (
    .ACLK   (clk),
    .ARESETN(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 = dark, 1 = clearing, 2 = displaying (row period = dwell visible cycles + 1 dark)
  int               m_mode;
  int               m_clr_left;
  int               m_dwell;
  int               m_pos;
  logic [ROW_W-1:0] m_row;
  logic [ROW_W-1:0] m_clr_idx;
  bit               m_disp;
  logic [COLS-1:0]  m_grid [2][ROWS];
  logic [ROWS-1:0]  e_sel;
  logic [COLS-1:0]  e_col;
  logic [COLS-1:0]  e_rd;
  logic             e_fd;
  logic             e_busy;

  task automatic model_reset();
    m_mode = 0; m_clr_left = 0; m_dwell = 1; m_pos = 0;
    m_row = '0; m_disp = 1'b0;
    m_grid = '{default: '0};
    e_sel = '0; e_col = '0; e_rd = '0; e_fd = 1'b0; e_busy = 1'b0;
  endtask

  task automatic show_row(input logic [ROW_W-1:0] r);
    m_mode  = 2;
    m_row   = r;
    m_dwell = int'(bus.scan_div) + 1;
    m_pos   = 0;
    e_sel   = ROWS'(1) << r;
    e_col   = m_grid[m_disp][r];
  endtask

  task automatic go_dark();
    m_mode = 0; m_row = '0; e_sel = '0; e_col = '0;
  endtask

  task automatic model_update();
    bit do_wr;
    bit wbank;
    e_rd  = m_grid[m_disp][bus.rd_row];
    e_fd  = 1'b0;
    do_wr = bus.cfg_wr_stb && (int'(bus.cfg_row) < ROWS) && (m_mode != 1) && !bus.ctrl_clear;
    wbank = SHADOW ? !m_disp : m_disp;
    if (bus.ctrl_clear) begin
      m_mode = 1; m_clr_left = ROWS; e_busy = 1'b1; e_sel = '0; e_col = '0; m_row = '0;
    end else if (m_mode == 1) begin
      m_clr_idx = ROW_W'(ROWS - m_clr_left);
      m_grid[0][m_clr_idx] = '0;
      m_grid[1][m_clr_idx] = '0;
      m_clr_left--;
      if (m_clr_left == 0) begin
        e_busy = 1'b0;
        if (bus.ctrl_enable) show_row('0);
        else go_dark();
      end
    end else if (m_mode == 2) begin
      if (!bus.ctrl_enable) go_dark();
      else if (m_pos < m_dwell - 1) m_pos++;
      else if (m_pos == m_dwell - 1) begin
        m_pos++;
        e_sel = '0;
        if (m_row == ROW_W'(ROWS - 1)) begin
          e_fd = 1'b1;
          if (SHADOW) m_disp = !m_disp;
        end
      end else begin
        show_row((m_row == ROW_W'(ROWS - 1)) ? ROW_W'(0) : m_row + ROW_W'(1));
      end
    end else if (bus.ctrl_enable) begin
      show_row('0);
    end
    if (do_wr) m_grid[wbank][bus.cfg_row[ROW_W-1:0]] = bus.cfg_data;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("row_sel",    32'(bus.row_sel),    32'(e_sel));
      check("col_data",   bus.col_data,        e_col);
      check("frame_done", 32'(bus.frame_done), 32'(e_fd));
      check("busy",       32'(bus.busy),       32'(e_busy));
      check("rd_data",    bus.rd_data,         e_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic write_row(input logic [ROW_W:0] r, input logic [COLS-1:0] d);
    bus.cfg_wr_stb = 1'b1; bus.cfg_row = r; bus.cfg_data = d;
    tick();
    bus.cfg_wr_stb = 1'b0;
  endtask

  task automatic wait_sel(input logic [ROWS-1:0] sel, input int bound, input string name);
    int n;
    n = 0;
    while (bus.row_sel !== sel && n < bound) begin
      tick();
      n++;
    end
    n_checks++;
    if (bus.row_sel !== sel) begin
      n_fail++;
      $display("FAIL %s: no row_sel 0x%04h within %0d cycles, last 0x%04h", name, sel, bound, bus.row_sel);
    end
  endtask

  task automatic wait_fd(input int bound, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_done !== 1'b1 && n < bound);
    n_checks++;
    if (bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_done got 0 for %0d cycles, required 1", name, bound);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  int fd_cnt, fd_first, fd_second, busy_cnt;
  bit seen_end;
  logic [COLS-1:0] exp_r3;

  initial begin
    rst_n = 1'b0;
    bus.cfg_wr_stb = 1'b0; bus.cfg_row = '0; bus.cfg_data = '0;
    bus.ctrl_enable = 1'b0; bus.ctrl_clear = 1'b0; bus.scan_div = '0; bus.rd_row = '0;
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_row_sel", 32'(bus.row_sel), 32'h0);
    check("reset_busy",    32'(bus.busy),    32'h0);

    // Row 3 pattern, dwell 3 cycles + 1 blank, 64-cycle frame
    exp_r3 = SHADOW ? 32'h0 : 32'hDEADBEEF;
    write_row(5'd3, 32'hDEADBEEF);
    bus.scan_div = 16'd2;
    bus.ctrl_enable = 1'b1;
    fd_cnt = 0; fd_first = 0; fd_second = 0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k == 13) begin
        check("row3_sel_first", 32'(bus.row_sel), 32'h0000_0008);
        check("row3_col_first", bus.col_data, exp_r3);
      end
      if (k == 15) check("row3_sel_last", 32'(bus.row_sel), 32'h0000_0008);
      if (k == 16) check("row3_blank", 32'(bus.row_sel), 32'h0);
      if (bus.frame_done) begin
        fd_cnt++;
        if (fd_cnt == 1) fd_first = k;
        else if (fd_cnt == 2) fd_second = k;
      end
    end
    check("frame_done_count",  32'(fd_cnt),    32'd2);
    check("frame_done_first",  32'(fd_first),  32'd64);
    check("frame_done_second", 32'(fd_second), 32'd128);

    // Out-of-range row is ignored; readback all rows
    write_row(5'd16, 32'hFFFFFFFF);
    for (int r = 0; r < ROWS; r++) begin
      bus.rd_row = ROW_W'(r);
      tick();
      check("readback_row", bus.rd_data, (r == 3) ? exp_r3 : 32'h0);
    end

    // Clear while scanning, with a simultaneous write and a write during busy
    bus.ctrl_clear = 1'b1;
    bus.cfg_wr_stb = 1'b1; bus.cfg_row = 5'd9; bus.cfg_data = 32'h99999999;
    tick();
    bus.ctrl_clear = 1'b0; bus.cfg_wr_stb = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    seen_end = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) begin
        bus.cfg_wr_stb = 1'b1; bus.cfg_row = 5'd7; bus.cfg_data = 32'hAAAA5555;
      end
      tick();
      bus.cfg_wr_stb = 1'b0;
      if (bus.busy) busy_cnt++;
      else if (!seen_end) begin
        seen_end = 1'b1;
        check("clear_restart_sel", 32'(bus.row_sel), 32'h0000_0001);
        check("clear_restart_col", bus.col_data, 32'h0);
      end
    end
    check("clear_busy_cycles", 32'(busy_cnt), 32'd16);
    bus.rd_row = 4'd7; tick(); check("clear_drop_wr_busy", bus.rd_data, 32'h0);
    bus.rd_row = 4'd9; tick(); check("clear_beats_wr",     bus.rd_data, 32'h0);
    bus.rd_row = 4'd3; tick(); check("clear_zeroed_row3",  bus.rd_data, 32'h0);

    // Write to the row being displayed does not disturb the current dwell
    bus.scan_div = 16'd7;
    write_row(5'd5, 32'h55AA55AA);
    wait_fd(400, "wait_fd_a");
    wait_sel(16'h0020, 400, "wait_row5_a");
    check("row5_col_before", bus.col_data, 32'h55AA55AA);
    tick(); tick();
    write_row(5'd5, 32'h0F0F0F0F);
    tick();
    check("row5_sel_hold", 32'(bus.row_sel), 32'h0000_0020);
    check("row5_col_hold", bus.col_data, 32'h55AA55AA);
    wait_fd(400, "wait_fd_b");
    wait_sel(16'h0020, 400, "wait_row5_b");
    check("row5_col_next", bus.col_data, 32'h0F0F0F0F);

    // Mid-frame write to row 0: readback/display timing depends on shadowing
    wait_sel(16'h0100, 400, "wait_row8");
    write_row(5'd0, 32'h00001234);
    bus.rd_row = 4'd0;
    tick();
    check("row0_rd_midframe", bus.rd_data, SHADOW ? 32'h0 : 32'h00001234);
    wait_fd(400, "wait_fd_c");
    tick();
    check("row0_sel_next", 32'(bus.row_sel), 32'h0000_0001);
    check("row0_col_next", bus.col_data, 32'h00001234);
    check("row0_rd_next",  bus.rd_data,  32'h00001234);

    // Disable mid-scan: dark next cycle, restart at row 0
    bus.scan_div = 16'd1;
    wait_sel(16'h0008, 400, "wait_row3");
    bus.ctrl_enable = 1'b0;
    tick();
    check("disable_sel", 32'(bus.row_sel), 32'h0);
    check("disable_col", bus.col_data, 32'h0);
    tick();
    bus.ctrl_enable = 1'b1;
    tick();
    check("reenable_sel", 32'(bus.row_sel), 32'h0000_0001);

    // Asynchronous reset mid-scan
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_row_sel",    32'(bus.row_sel),    32'h0);
    check("async_rst_col_data",   bus.col_data,        32'h0);
    check("async_rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("async_rst_busy",       32'(bus.busy),       32'h0);
    check("async_rst_rd_data",    bus.rd_data,         32'h0);
    model_reset();
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
